// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART frame receiver (start, 8 data bits LSB first, optional parity, stop).
// Optional build macro UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 majority of
// rx_s at mid-1, mid and mid+1, taken one cycle after mid-bit.
module uart_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       PAR_EN,
   input  logic       parity_type,
   output logic [7:0] p_data,
   output logic       data_valid,
   output logic       par_err,
   output logic       stop_err,
   output logic       busy
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned OFS = 1;
`else
   localparam int unsigned OFS = 0;
`endif
   localparam logic [CW-1:0] START_PT = CW'(HALF - 1 + OFS);
   localparam logic [CW-1:0] BIT_PT   = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   logic          rx_meta, rx_s;
   logic [1:0]    flush_q;
   logic          rx_prev_q, fall_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          par_en_q, par_en_d, par_odd_q, par_odd_d, par_bad_q, par_bad_d;
   logic          busy_q, busy_d;
   logic [7:0]    p_data_q, p_data_d;
   logic          dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic          confirm;
   logic          samp;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   // Two-deep history of rx_s for the 2-of-3 vote
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist_q <= 2'b11;
      else     hist_q <= {hist_q[0], rx_s};
   end

   assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign samp = rx_s;
`endif

   // Synchronizer and registered falling-edge detect; rx_prev_q stays low until the
   // synchronizer holds real line data, so a line low out of reset is not a start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         flush_q   <= 2'b00;
         rx_prev_q <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         rx_meta   <= rx_in;
         rx_s      <= rx_meta;
         flush_q   <= {flush_q[0], 1'b1};
         rx_prev_q <= rx_s & flush_q[1];
         fall_q    <= rx_prev_q & ~rx_s;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         par_bad_q <= 1'b0;
         busy_q    <= 1'b0;
         p_data_q  <= 8'h00;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         par_bad_q <= par_bad_d;
         busy_q    <= busy_d;
         p_data_q  <= p_data_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   // Next-state: bit timing, sampling and end-of-frame decision
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_d     = bit_q;
      sh_d      = sh_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      par_bad_d = par_bad_q;
      busy_d    = busy_q;
      p_data_d  = p_data_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;
      confirm   = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (fall_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == START_PT) begin
               cnt_d = '0;
               if (!samp) begin
                  confirm   = 1'b1;
                  busy_d    = 1'b1;
                  par_en_d  = PAR_EN;
                  par_odd_d = parity_type;
                  par_bad_d = 1'b0;
                  bit_d     = '0;
                  state_d   = StData;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (cnt_q == BIT_PT) begin
               cnt_d = '0;
               sh_d  = {samp, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = par_en_q ? StParity : StStop;
            end
         end
         StParity: begin
            if (cnt_q == BIT_PT) begin
               cnt_d = '0;
               // Even: error when XOR(data) != p; odd: error when XOR(data) == p
               par_bad_d = (^sh_q) ^ samp ^ par_odd_q;
               state_d   = StStop;
            end
         end
         StStop: begin
            if (cnt_q == BIT_PT) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
               se_d    = ~samp;
               pe_d    = par_bad_q;
               if (samp && !par_bad_q) begin
                  dv_d     = 1'b1;
                  p_data_d = sh_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // busy covers the start-confirmation cycle itself
   assign busy       = busy_q | confirm;
   assign p_data     = p_data_q;
   assign data_valid = dv_q;
   assign par_err    = pe_q;
   assign stop_err   = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame (CLKS_PER_BIT = 16).
module tb_uart_rx_frame;

   localparam int C = 16;
   localparam int H = C / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT9 = 157;
`else
   localparam int LAT9 = 156;
`endif

   logic       clk, rst, rx_in, par_en, parity_type;
   logic [7:0] p_data;
   logic       data_valid, par_err, stop_err, busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int dv_cnt, pe_cnt, se_cnt, both_cnt, bad_cnt, busy_cnt, last_dv, prev_dv;

   uart_rx_frame #(.CLKS_PER_BIT(C)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .PAR_EN      (par_en),
      .parity_type (parity_type),
      .p_data      (p_data),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stop_err    (stop_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid) begin
            dv_cnt++;
            prev_dv = last_dv;
            last_dv = cyc;
         end
         if (par_err) pe_cnt++;
         if (stop_err) se_cnt++;
         if (par_err && stop_err) both_cnt++;
         if (data_valid && (par_err || stop_err)) bad_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      dv_cnt = 0; pe_cnt = 0; se_cnt = 0; both_cnt = 0; bad_cnt = 0;
      busy_cnt = 0; last_dv = 0; prev_dv = 0;
   endtask

   // Drive a level for n whole cycles; leaves the bench at posedge+1
   task automatic hold(input logic v, input int n);
      rx_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic sbit, input int glitch_bit);
      start_cyc = cyc;
      hold(1'b0, C);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_bit) begin
            hold(d[i], H + 1);
            hold(~d[i], 1);
            hold(d[i], C - H - 2);
         end else begin
            hold(d[i], C);
         end
      end
      if (pen) hold(pbit, C);
      hold(sbit, C);
   endtask

   initial begin
      rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; parity_type = 1'b0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      check("rst_p_data", 32'(p_data), 32'h00);
      check("rst_dv", 32'(data_valid), 32'h0);
      check("rst_par_err", 32'(par_err), 32'h0);
      check("rst_stop_err", 32'(stop_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      hold(1'b1, 8);

      // 0xA5, no parity
      clr();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      hold(1'b1, 4);
      check("a5_dv_cnt", 32'(dv_cnt), 32'd1);
      check("a5_p_data", 32'(p_data), 32'hA5);
      check("a5_errs", 32'(pe_cnt + se_cnt), 32'd0);
      check("a5_busy_cycles", 32'(busy_cnt), 32'd145);
      check("a5_latency", 32'(last_dv - start_cyc), 32'(LAT9));

      // Even parity: 0x3C with p=0 valid, with p=1 parity error
      par_en = 1'b1; parity_type = 1'b0;
      clr();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
      hold(1'b1, 4);
      check("even_ok_dv", 32'(dv_cnt), 32'd1);
      check("even_ok_p_data", 32'(p_data), 32'h3C);
      check("even_ok_pe", 32'(pe_cnt), 32'd0);
      clr();
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
      hold(1'b1, 4);
      check("even_bad_dv", 32'(dv_cnt), 32'd0);
      check("even_bad_pe", 32'(pe_cnt), 32'd1);
      check("even_bad_se", 32'(se_cnt), 32'd0);
      check("even_bad_p_data", 32'(p_data), 32'h3C);

      // Odd parity: 0x01 with p=1 is a parity error; stop driven low too
      parity_type = 1'b1;
      clr();
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, -1);
      check("odd_both_pe", 32'(pe_cnt), 32'd1);
      check("odd_both_se", 32'(se_cnt), 32'd1);
      check("odd_both_same_cycle", 32'(both_cnt), 32'd1);
      check("odd_both_dv", 32'(dv_cnt), 32'd0);
      check("odd_both_p_data", 32'(p_data), 32'h3C);
      clr();
      hold(1'b0, 3 * C);
      check("low_line_busy", 32'(busy_cnt), 32'd0);
      check("low_line_dv", 32'(dv_cnt), 32'd0);
      hold(1'b1, 2 * C);
      clr();
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, -1);
      hold(1'b1, 4);
      check("odd_ok_dv", 32'(dv_cnt), 32'd1);
      check("odd_ok_p_data", 32'(p_data), 32'h01);

      // Reset in the middle of the data bits of 0x55
      par_en = 1'b0; parity_type = 1'b0;
      clr();
      hold(1'b0, C);
      hold(1'b1, C); hold(1'b0, C); hold(1'b1, C); hold(1'b0, H);
      check("pre_rst_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_p_data", 32'(p_data), 32'h00);
      check("mid_rst_dv", 32'(data_valid), 32'h0);
      hold(1'b1, 4);
      rst = 1'b0;
      hold(1'b1, 3 * C);
      check("rst_frame_no_dv", 32'(dv_cnt), 32'd0);
      clr();
      send_frame(8'h99, 1'b0, 1'b0, 1'b1, -1);
      hold(1'b1, 4);
      check("after_rst_dv", 32'(dv_cnt), 32'd1);
      check("after_rst_p_data", 32'(p_data), 32'h99);
      check("after_rst_errs", 32'(pe_cnt + se_cnt + bad_cnt), 32'd0);

      // 3-cycle low glitch is a false start
      clr();
      hold(1'b0, 3);
      hold(1'b1, 3 * C);
      check("false_start_busy", 32'(busy_cnt), 32'd0);
      check("false_start_pulses", 32'(dv_cnt + pe_cnt + se_cnt), 32'd0);

      // Back-to-back 0xFF then 0x00
      clr();
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1);
      hold(1'b1, 4);
      check("b2b_dv_cnt", 32'(dv_cnt), 32'd2);
      check("b2b_spacing", 32'(last_dv - prev_dv), 32'd160);
      check("b2b_p_data", 32'(p_data), 32'h00);
      check("b2b_errs", 32'(pe_cnt + se_cnt), 32'd0);

`ifdef UART_RX_MAJORITY_EN
      // Single-cycle glitch at mid-bit of data bit 3 is voted out
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1);
      hold(1'b1, 4);
      clr();
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, 3);
      hold(1'b1, 4);
      check("maj_dv", 32'(dv_cnt), 32'd1);
      check("maj_p_data", 32'(p_data), 32'h00);
      check("maj_latency", 32'(last_dv - start_cyc), 32'd157);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
